qos_vc_arbiter: RTL and testbench

- Weighted round-robin read scheduler for the four virtual-channel (VC) FIFOs of the PCIe QoS module.
- Decides, every cycle, which non-empty, non-paused VC FIFO is popped toward the shared output FIFO.
- Honours the per-VC Pause mask from the flow-control FSM and backpressure from the output FIFO.
- Sits between the VC FIFO bank and the output FIFO; configured through the same set_init phase as the FSM.

---
 rtl/qos_vc_arbiter.sv | 143 ++++++++++++++
 tb/tb_qos_vc_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qos_vc_arbiter.sv
// Weighted round-robin pop scheduler for four PCIe QoS virtual-channel FIFOs.
// Define QOS_ARB_WEIGHT_EN for weighted grants; otherwise each grant is a single pop.
module qos_vc_arbiter #(
    parameter int unsigned WEIGHT_W = 3
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  set_init,
    input  logic [4*WEIGHT_W-1:0] weights,
    input  logic [3:0]            empty,
    input  logic [3:0]            pause,
    input  logic                  out_full,
    output logic [3:0]            pop,
    output logic [1:0]            vc_sel,
    output logic                  valid,
    output logic                  idle
);

    localparam logic [1:0] INIT   = 2'd0;
    localparam logic [1:0] IDLE   = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;

    localparam logic [WEIGHT_W-1:0] ONE = {{(WEIGHT_W-1){1'b0}}, 1'b1};

    logic [1:0]          state_q, state_d;
    logic [1:0]          cur_q, cur_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [WEIGHT_W-1:0] next_credit;
    logic [3:0]          eligible;
    logic                found;
    logic [1:0]          next;
    logic                pop_any;
    logic                valid_q, idle_q;
    logic [1:0]          vc_sel_q;

    assign eligible = ~empty & ~pause & {4{~out_full}};

    // Scan ptr+1, ptr+2, ptr+3, ptr; the 2-bit add wraps mod 4.
    always_comb begin
        logic [1:0] cand;
        found = 1'b0;
        next  = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                next  = cand;
            end
        end
    end

`ifdef QOS_ARB_WEIGHT_EN
    logic [WEIGHT_W-1:0] wreg_q [4];

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) wreg_q[i] <= ONE;
        end else if (set_init) begin
            for (int i = 0; i < 4; i++) begin
                wreg_q[i] <= (weights[i*WEIGHT_W +: WEIGHT_W] == '0) ? ONE
                                                                   : weights[i*WEIGHT_W +: WEIGHT_W];
            end
        end
    end

    assign next_credit = wreg_q[next];
`else
    logic unused_weights;
    assign unused_weights = ^weights;
    assign next_credit    = ONE;
`endif

    always_comb begin
        pop = '0;
        if (!set_init && state_q == ACTIVE && eligible[cur_q] && credit_q != '0) begin
            pop[cur_q] = 1'b1;
        end
    end

    assign pop_any = |pop;

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        if (set_init) begin
            state_d = INIT;
        end else begin
            case (state_q)
                INIT: state_d = IDLE;
                IDLE: begin
                    if (found) begin
                        cur_d    = next;
                        ptr_d    = next;
                        credit_d = next_credit;
                        state_d  = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (pop_any) credit_d = credit_q - ONE;
                    // Last pop of a grant or a stalled VC: hand over in this same cycle.
                    if (!pop_any || credit_q == ONE) begin
                        if (found) begin
                            cur_d    = next;
                            ptr_d    = next;
                            credit_d = next_credit;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = INIT;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q  <= INIT;
            cur_q    <= 2'd0;
            ptr_q    <= 2'd3;
            credit_q <= '0;
            valid_q  <= 1'b0;
            vc_sel_q <= 2'd0;
            idle_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            valid_q  <= pop_any;
            idle_q   <= (state_d == IDLE);
            if (pop_any) vc_sel_q <= cur_q;
        end
    end

    assign valid  = valid_q;
    assign vc_sel = vc_sel_q;
    assign idle   = idle_q;

endmodule

// File: tb/tb_qos_vc_arbiter.sv
// Self-checking bench for qos_vc_arbiter: directed phases plus random traffic
// against a behavioural scheduler model with per-VC FIFO occupancy.
module tb_qos_vc_arbiter;

    localparam int WW = 3;

    logic          CLK = 1'b0;
    logic          reset;
    logic          set_init;
    logic [4*WW-1:0] weights;
    logic [3:0]    empty;
    logic [3:0]    pause;
    logic          out_full;
    logic [3:0]    pop;
    logic [1:0]    vc_sel;
    logic          valid;
    logic          idle;

    int total = 0;
    int bad   = 0;

    // Behavioural model: mode 0=init, 1=idle, 2=serving.
    int         cnt [4];
    int         m_mode, m_cur, m_left, m_ptr;
    int         m_w [4];
    logic       m_valid;
    logic [1:0] m_sel;

    int  seq_q[$];
    bit  rec;
    int  pop2_cnt;
    int  exp_seq [10];
    int  exp_rst [4];

    qos_vc_arbiter #(.WEIGHT_W(WW)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .set_init (set_init),
        .weights  (weights),
        .empty    (empty),
        .pause    (pause),
        .out_full (out_full),
        .pop      (pop),
        .vc_sel   (vc_sel),
        .valid    (valid),
        .idle     (idle)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit elig(input int i);
        return cnt[i] != 0 && !pause[i] && !out_full;
    endfunction

    function automatic int find_next();
        for (int k = 1; k <= 4; k++) begin
            if (elig((m_ptr + k) % 4)) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_pop();
        if (set_init || m_mode != 2) return 4'b0000;
        if (elig(m_cur) && m_left > 0) return 4'(1 << m_cur);
        return 4'b0000;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_cur   = 0;
        m_ptr   = 3;
        m_left  = 0;
        m_valid = 1'b0;
        m_sel   = 2'd0;
        for (int i = 0; i < 4; i++) m_w[i] = 1;
    endtask

    task automatic grant(input int n);
        m_cur  = n;
        m_ptr  = n;
        m_left = m_w[n];
        m_mode = 2;
    endtask

    task automatic model_step();
        logic [3:0] p;
        int n;
        p = exp_pop();
        m_valid = |p;
        if (|p) m_sel = 2'(m_cur);
        if (set_init) begin
            m_mode = 0;
`ifdef QOS_ARB_WEIGHT_EN
            for (int i = 0; i < 4; i++) begin
                n = int'(weights[i*WW +: WW]);
                m_w[i] = (n == 0) ? 1 : n;
            end
`endif
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            n = find_next();
            if (n >= 0) grant(n);
        end else begin
            if (|p) m_left--;
            if (!(|p) || m_left == 0) begin
                n = find_next();
                if (n >= 0) grant(n);
                else m_mode = 1;
            end
        end
        for (int i = 0; i < 4; i++) if (p[i]) cnt[i]--;
    endtask

    // Entered just after a falling edge; leaves at the next falling edge.
    task automatic cycle();
        for (int i = 0; i < 4; i++) empty[i] = (cnt[i] == 0);
        #1;
        chk("pop", pop, exp_pop());
        chk("valid", {3'b0, valid}, {3'b0, m_valid});
        chk("vc_sel", {2'b0, vc_sel}, {2'b0, m_sel});
        chk("idle", {3'b0, idle}, {3'b0, (m_mode == 1)});
        if (rec && |pop) begin
            for (int i = 0; i < 4; i++) if (pop[i]) seq_q.push_back(i);
        end
        pop2_cnt += int'(pop[2]);
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    initial begin
`ifdef QOS_ARB_WEIGHT_EN
        exp_seq = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
        exp_rst = '{0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
        exp_rst = '{0, 1, 2, 3};
`endif
        rec      = 1'b0;
        pop2_cnt = 0;
        reset    = 1'b0;
        set_init = 1'b0;
        weights  = '0;
        empty    = 4'hF;
        pause    = 4'h0;
        out_full = 1'b0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        model_reset();

        // Reset values
        @(posedge CLK);
        #2;
        chk("rst_pop", pop, 4'b0000);
        chk("rst_valid", {3'b0, valid}, 4'b0000);
        chk("rst_vc_sel", {2'b0, vc_sel}, 4'b0000);
        chk("rst_idle", {3'b0, idle}, 4'b0000);
        @(negedge CLK);
        #2;
        reset = 1'b1;

        // Init phase with weights VC3..VC0 = 1,2,3,4
        for (int i = 0; i < 4; i++) cnt[i] = 1000;
        set_init = 1'b1;
        weights  = {3'd1, 3'd2, 3'd3, 3'd4};
        cycle();
        cycle();
        set_init = 1'b0;

        // Full traffic: weighted (or plain) rotation
        seq_q.delete();
        rec = 1'b1;
        for (int c = 0; c < 14; c++) cycle();
        rec = 1'b0;
        chk("seq_len", (seq_q.size() >= 10) ? 4'd1 : 4'd0, 4'd1);
        for (int i = 0; i < 10 && i < seq_q.size(); i++) begin
            chk("seq_vc", 4'(seq_q[i]), 4'(exp_seq[i]));
        end
        for (int c = 0; c < 10; c++) cycle();

        // Pause VC1/VC2
        pause = 4'b0110;
        for (int c = 0; c < 4; c++) cycle();
        pause = 4'b0000;
        for (int c = 0; c < 8; c++) cycle();

        // Output FIFO full mid-burst
        out_full = 1'b1;
        cycle();
        cycle();
        out_full = 1'b0;
        for (int c = 0; c < 8; c++) cycle();

        // Only VC2 holds a single word
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int c = 0; c < 3; c++) cycle();
        cnt[2]   = 1;
        pop2_cnt = 0;
        for (int c = 0; c < 6; c++) cycle();
        chk("vc2_single_pop", 4'(pop2_cnt), 4'd1);
        chk("vc2_then_idle", {3'b0, idle}, 4'd1);

        // Random traffic with occasional re-init
        for (int c = 0; c < 400; c++) begin
            pause    = ($urandom % 3 == 0) ? 4'($urandom) : 4'b0000;
            out_full = ($urandom % 8 == 0);
            set_init = ($urandom % 50 == 0);
            weights  = 12'($urandom);
            for (int i = 0; i < 4; i++) begin
                if (cnt[i] == 0 && $urandom % 4 == 0) cnt[i] = $urandom_range(1, 6);
            end
            cycle();
        end
        set_init = 1'b0;
        pause    = 4'b0000;
        out_full = 1'b0;

        // Asynchronous reset during a burst
        for (int i = 0; i < 4; i++) cnt[i] = 1000;
        for (int c = 0; c < 5; c++) cycle();
        #1;
        reset = 1'b0;
        #1;
        chk("async_pop", pop, 4'b0000);
        chk("async_valid", {3'b0, valid}, 4'b0000);
        chk("async_idle", {3'b0, idle}, 4'b0000);
        chk("async_vc_sel", {2'b0, vc_sel}, 4'b0000);
        @(negedge CLK);
        #2;
        reset = 1'b1;
        model_reset();
        set_init = 1'b1;
        weights  = {3'd1, 3'd2, 3'd3, 3'd4};
        cycle();
        set_init = 1'b0;
        seq_q.delete();
        rec = 1'b1;
        for (int c = 0; c < 8; c++) cycle();
        rec = 1'b0;
        chk("rst_seq_len", (seq_q.size() >= 4) ? 4'd1 : 4'd0, 4'd1);
        for (int i = 0; i < 4 && i < seq_q.size(); i++) begin
            chk("rst_seq_vc", 4'(seq_q[i]), 4'(exp_rst[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
